axi4_burst_to_apb: RTL

//  AXI4 slave to APB master bridge. Sits directly upstream of the SDRAM APB front-end.

---
 rtl/axi4_burst_to_apb.sv | 251 +++++++++++++++++++++++++
 1 files changed

// File: rtl/axi4_burst_to_apb.sv
// axi4_burst_to_apb
//   AXI4 slave to APB master bridge. One AXI burst (FIXED/INCR/WRAP, up to
//   256 beats) is split into single APB transfers. One transaction is in
//   flight at a time and the AXI ID is echoed back on R/B.
//
// Ports
//   clock, reset           system clock, synchronous active-high reset
//   in_aw* / in_w* / in_b* AXI4 write address, write data, write response
//   in_ar* / in_r*         AXI4 read address, read data
//   out_p*                 APB master request (psel/penable/pwrite/paddr/
//                          pwdata/pstrb/pprot)
//   out_pready/prdata/pslverr  APB completion inputs
module axi4_burst_to_apb #(
  parameter int ID_W   = 4,
  parameter int ADDR_W = 32
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              in_awvalid,
  output logic              in_awready,
  input  logic [ADDR_W-1:0] in_awaddr,
  input  logic [ID_W-1:0]   in_awid,
  input  logic [7:0]        in_awlen,
  input  logic [2:0]        in_awsize,
  input  logic [1:0]        in_awburst,
  input  logic              in_wvalid,
  output logic              in_wready,
  input  logic [31:0]       in_wdata,
  input  logic [3:0]        in_wstrb,
  input  logic              in_wlast,
  output logic              in_bvalid,
  input  logic              in_bready,
  output logic [1:0]        in_bresp,
  output logic [ID_W-1:0]   in_bid,
  input  logic              in_arvalid,
  output logic              in_arready,
  input  logic [ADDR_W-1:0] in_araddr,
  input  logic [ID_W-1:0]   in_arid,
  input  logic [7:0]        in_arlen,
  input  logic [2:0]        in_arsize,
  input  logic [1:0]        in_arburst,
  output logic              in_rvalid,
  input  logic              in_rready,
  output logic [31:0]       in_rdata,
  output logic [1:0]        in_rresp,
  output logic              in_rlast,
  output logic [ID_W-1:0]   in_rid,
  output logic              out_psel,
  output logic              out_penable,
  output logic              out_pwrite,
  output logic [ADDR_W-1:0] out_paddr,
  output logic [31:0]       out_pwdata,
  output logic [3:0]        out_pstrb,
  output logic [2:0]        out_pprot,
  input  logic              out_pready,
  input  logic [31:0]       out_prdata,
  input  logic              out_pslverr
);

  typedef enum logic [2:0] {
    IDLE, RSETUP, RACCESS, RRESP, WDATA, WSETUP, WACCESS, BRESP
  } state_t;

  state_t              r_state;
  logic [ADDR_W-1:0]   r_addr;
  logic [ID_W-1:0]     r_id;
  logic [7:0]          r_len;
  logic [2:0]          r_size;
  logic [1:0]          r_burst;
  logic [7:0]          r_beat;
  logic                r_err;
  logic                r_badSize;
  logic                r_readPri;
  logic [31:0]         r_rdata;
  logic [1:0]          r_rresp;
  logic [31:0]         r_pwdata;
  logic [3:0]          r_pstrb;

  logic                w_idle;
  logic                w_arFire;
  logic                w_awFire;
  logic                w_lastBeat;
  logic                w_wrapOk;
  logic [ADDR_W-1:0]   w_step;
  logic [ADDR_W-1:0]   w_incr;
  logic [ADDR_W-1:0]   w_wrapMask;
  logic [ADDR_W-1:0]   w_nextAddr;
  logic                w_unused;

  // wlast is not used for beat counting; the latched len is authoritative.
  assign w_unused = in_wlast;

  // Address-channel arbitration: r_readPri says whether read holds priority
  // this time. It flips to the other side after each served transaction, so
  // the last-served direction loses a simultaneous request. Readies are held
  // low while reset is asserted.
  assign w_idle     = (r_state == IDLE) && !reset;
  assign in_arready = w_idle && (r_readPri || !in_awvalid);
  assign in_awready = w_idle && (!r_readPri || !in_arvalid);
  assign w_arFire   = in_arvalid && in_arready;
  assign w_awFire   = in_awvalid && in_awready;
  assign w_lastBeat = (r_beat == r_len);

  // Next beat address. WRAP wraps inside a (len+1)*step aligned window;
  // a WRAP with an illegal length, and the reserved burst type, step like INCR.
  always_comb begin
    w_step     = {{(ADDR_W-1){1'b0}}, 1'b1} << r_size;
    w_incr     = r_addr + w_step;
    w_wrapOk   = (r_len == 8'd1) || (r_len == 8'd3) || (r_len == 8'd7) || (r_len == 8'd15);
    w_wrapMask = (({{(ADDR_W-8){1'b0}}, r_len} + {{(ADDR_W-1){1'b0}}, 1'b1}) << r_size)
                 - {{(ADDR_W-1){1'b0}}, 1'b1};
    w_nextAddr = w_incr;
    case (r_burst)
      2'b00:   w_nextAddr = r_addr;
      2'b10:   w_nextAddr = w_wrapOk ? ((r_addr & ~w_wrapMask) | (w_incr & w_wrapMask)) : w_incr;
      default: w_nextAddr = w_incr;
    endcase
  end

  // Handshake and APB phase outputs decode straight off the state register,
  // so they change only on clock edges. The APB request fields come from
  // registers that are stable from SETUP through the end of ACCESS.
  assign out_psel    = (r_state == RSETUP) || (r_state == RACCESS) ||
                       (r_state == WSETUP) || (r_state == WACCESS);
  assign out_penable = (r_state == RACCESS) || (r_state == WACCESS);
  assign out_pwrite  = (r_state == WSETUP) || (r_state == WACCESS);
  assign out_paddr   = r_addr;
  assign out_pwdata  = r_pwdata;
  assign out_pstrb   = r_pstrb;
  assign out_pprot   = 3'b000;
  assign in_wready   = (r_state == WDATA);
  assign in_rvalid   = (r_state == RRESP);
  assign in_rlast    = (r_state == RRESP) && w_lastBeat;
  assign in_rdata    = r_rdata;
  assign in_rresp    = r_rresp;
  assign in_rid      = r_id;
  assign in_bvalid   = (r_state == BRESP);
  assign in_bresp    = ((r_state == BRESP) && r_err) ? 2'b10 : 2'b00;
  assign in_bid      = r_id;

  // Main burst sequencer. Oversized beats (size > 2) bypass the APB states:
  // reads go straight to RRESP with SLVERR and zero data, writes consume W
  // beats in WDATA and flag the error for the B response.
  always_ff @(posedge clock) begin
    if (reset) begin
      r_state   <= IDLE;
      r_addr    <= '0;
      r_id      <= '0;
      r_len     <= '0;
      r_size    <= '0;
      r_burst   <= '0;
      r_beat    <= '0;
      r_err     <= 1'b0;
      r_badSize <= 1'b0;
      r_readPri <= 1'b1;
      r_rdata   <= '0;
      r_rresp   <= '0;
      r_pwdata  <= '0;
      r_pstrb   <= '0;
    end else begin
      case (r_state)
        IDLE: begin
          if (w_arFire) begin
            r_addr    <= in_araddr;
            r_id      <= in_arid;
            r_len     <= in_arlen;
            r_size    <= in_arsize;
            r_burst   <= in_arburst;
            r_beat    <= '0;
            r_err     <= 1'b0;
            r_badSize <= (in_arsize > 3'd2);
            r_readPri <= 1'b0;
            r_pstrb   <= '0;
            if (in_arsize > 3'd2) begin
              r_rdata <= '0;
              r_rresp <= 2'b10;
              r_state <= RRESP;
            end else begin
              r_state <= RSETUP;
            end
          end else if (w_awFire) begin
            r_addr    <= in_awaddr;
            r_id      <= in_awid;
            r_len     <= in_awlen;
            r_size    <= in_awsize;
            r_burst   <= in_awburst;
            r_beat    <= '0;
            r_err     <= 1'b0;
            r_badSize <= (in_awsize > 3'd2);
            r_readPri <= 1'b1;
            r_state   <= WDATA;
          end
        end
        RSETUP: r_state <= RACCESS;
        RACCESS: begin
          if (out_pready) begin
            r_rdata <= out_prdata;
            r_rresp <= out_pslverr ? 2'b10 : 2'b00;
            r_state <= RRESP;
          end
        end
        RRESP: begin
          if (in_rready) begin
            if (w_lastBeat) begin
              r_state <= IDLE;
            end else begin
              r_addr  <= w_nextAddr;
              r_beat  <= r_beat + 8'd1;
              r_state <= r_badSize ? RRESP : RSETUP;
            end
          end
        end
        WDATA: begin
          if (in_wvalid) begin
            if (r_badSize) begin
              r_err <= 1'b1;
              if (w_lastBeat) begin
                r_state <= BRESP;
              end else begin
                r_addr <= w_nextAddr;
                r_beat <= r_beat + 8'd1;
              end
            end else begin
              r_pwdata <= in_wdata;
              r_pstrb  <= in_wstrb;
              r_state  <= WSETUP;
            end
          end
        end
        WSETUP: r_state <= WACCESS;
        WACCESS: begin
          if (out_pready) begin
            r_err <= r_err | out_pslverr;
            if (w_lastBeat) begin
              r_state <= BRESP;
            end else begin
              r_addr  <= w_nextAddr;
              r_beat  <= r_beat + 8'd1;
              r_state <= WDATA;
            end
          end
        end
        BRESP: begin
          if (in_bready) r_state <= IDLE;
        end
        default: r_state <= IDLE;
      endcase
    end
  end

endmodule
